// File: rtl/maxnet_datapath.sv
// maxnet_datapath
//   Datapath for a four-lane MAXNET winner-take-all network. Each computed
//   iteration subtracts an eps-weighted sum of the other lanes from every
//   activation, clamping at zero. The iteration runs through two pipeline
//   registers (P, N), so a result from N is valid two edges after A settles.
//   Sequencing of iterations is left to an external controller.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   init_w     capture w_in into EPS
//   init_x     capture x_in into X
//   load_a     write activation registers A0..A3
//   load_sel   A source during load_a: 1 = X, 0 = computed N
//   w_in       inhibition weight eps, unsigned Q0.8
//   x_in       four 8-bit inputs, lane i = x_in[8i+7:8i]
//   a_out      A0..A3 packed in the same lane order
//   isfinished at most one A lane is nonzero
//   win_idx    index of the nonzero lane (0 unless win_valid)
//   win_valid  exactly one A lane is nonzero
//   iter_cnt   completed computed iterations, saturating at 255
module maxnet_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_w,
    input  logic        init_x,
    input  logic        load_a,
    input  logic        load_sel,
    input  logic [7:0]  w_in,
    input  logic [31:0] x_in,
    output logic [31:0] a_out,
    output logic        isfinished,
    output logic [1:0]  win_idx,
    output logic        win_valid,
    output logic [7:0]  iter_cnt
);

    logic [7:0]       eps_r;
    logic [3:0][7:0]  x_r;
    logic [3:0][7:0]  a_r;
    logic [3:0][9:0]  p_r;
    logic [3:0][7:0]  n_r;

    logic [3:0][9:0]  p_next;
    logic [3:0][7:0]  n_next;
    logic [9:0]       total;
    logic [3:0]       nz;
    logic [2:0]       nz_cnt;

    // Stage 1: sum of the other lanes is formed as total minus own lane;
    // the full 18-bit product is truncated once.
    always_comb begin
        logic [9:0]  others;
        logic [17:0] prod;
        total = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            total = total + {2'b00, a_r[i[1:0]]};
        end
        p_next = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            others = total - {2'b00, a_r[i[1:0]]};
            prod   = {8'd0, others} * {10'd0, eps_r};
            p_next[i[1:0]] = prod[17:8];
        end
    end

    // Stage 2: ReLU(A - P); P can exceed 255, so compare at 10 bits.
    always_comb begin
        n_next = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if ({2'b00, a_r[i[1:0]]} >= p_r[i[1:0]]) begin
                n_next[i[1:0]] = a_r[i[1:0]] - p_r[i[1:0]][7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eps_r    <= '0;
            x_r      <= '0;
            p_r      <= '0;
            n_r      <= '0;
            a_r      <= '0;
            iter_cnt <= '0;
        end else begin
            if (init_w) eps_r <= w_in;
            if (init_x) x_r   <= x_in;
            p_r <= p_next;
            n_r <= n_next;
            if (load_a) begin
                if (load_sel) begin
                    a_r      <= x_r;
                    iter_cnt <= '0;
                end else begin
                    a_r <= n_r;
                    if (iter_cnt != 8'hFF) iter_cnt <= iter_cnt + 8'd1;
                end
            end
        end
    end

    // Convergence status, combinational from A.
    always_comb begin
        nz_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            nz[i[1:0]] = |a_r[i[1:0]];
            nz_cnt     = nz_cnt + {2'b00, nz[i[1:0]]};
        end
        isfinished = (nz_cnt <= 3'd1);
        win_valid  = (nz_cnt == 3'd1);
        win_idx    = '0;
        if (win_valid) begin
            if (nz[3])      win_idx = 2'd3;
            else if (nz[2]) win_idx = 2'd2;
            else if (nz[1]) win_idx = 2'd1;
            else            win_idx = 2'd0;
        end
    end

    assign a_out = a_r;

endmodule

// File: tb/tb_maxnet_datapath.sv
module tb_maxnet_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_w, init_x, load_a, load_sel;
    logic [7:0]  w_in;
    logic [31:0] x_in;
    logic [31:0] a_out;
    logic        isfinished;
    logic [1:0]  win_idx;
    logic        win_valid;
    logic [7:0]  iter_cnt;

    always #5 clk = ~clk;

    maxnet_datapath dut (
        .clk(clk), .rst(rst), .init_w(init_w), .init_x(init_x),
        .load_a(load_a), .load_sel(load_sel), .w_in(w_in), .x_in(x_in),
        .a_out(a_out), .isfinished(isfinished), .win_idx(win_idx),
        .win_valid(win_valid), .iter_cnt(iter_cnt)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic        isf;
        logic [1:0]  idx;
        logic        v;
        logic [7:0]  it;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] pk(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic expect_out(input string name, input logic [31:0] a,
                              input logic isf, input logic [1:0] idx,
                              input logic v, input logic [7:0] it);
        exp_t e;
        e.name = name; e.a = a; e.isf = isf; e.idx = idx; e.v = v; e.it = it;
        q.push_back(e);
    endtask

    // One clock of stimulus; controls are single-cycle pulses.
    task automatic cyc(input logic la, input logic ls, input logic iw,
                       input logic ix, input logic [7:0] w, input logic [31:0] x);
        @(negedge clk); #1;
        load_a = la; load_sel = ls; init_w = iw; init_x = ix; w_in = w; x_in = x;
        @(posedge clk); #1;
        load_a = 0; load_sel = 0; init_w = 0; init_x = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 8'd0, 32'd0);
    endtask

    // Two idle cycles (MULT, ADD) then write-back from N.
    task automatic iterate();
        idle();
        idle();
        cyc(1, 0, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic setup(input logic [7:0] w, input logic [31:0] x);
        cyc(0, 0, 1, 1, w, x);
        cyc(1, 1, 0, 0, 8'd0, 32'd0);
    endtask

    // Monitor: compares whatever the stimulus has posted, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (a_out !== e.a || isfinished !== e.isf || win_idx !== e.idx ||
                    win_valid !== e.v || iter_cnt !== e.it) begin
                    errors++;
                    $display("FAIL %s: got a=%h isf=%b idx=%0d v=%b it=%0d, want a=%h isf=%b idx=%0d v=%b it=%0d",
                             e.name, a_out, isfinished, win_idx, win_valid, iter_cnt,
                             e.a, e.isf, e.idx, e.v, e.it);
                end
            end
        end
    end

    initial begin
        rst = 1; init_w = 0; init_x = 0; load_a = 0; load_sel = 0;
        w_in = 0; x_in = 0;

        @(posedge clk); #1;
        expect_out("reset_active", 32'd0, 1, 0, 0, 0);
        @(negedge clk); #1;
        rst = 0;
        idle();
        expect_out("after_reset", 32'd0, 1, 0, 0, 0);

        // Basic convergence
        setup(8'd64, pk(10, 20, 30, 40));
        expect_out("conv_load", pk(10, 20, 30, 40), 0, 0, 0, 0);
        iterate(); expect_out("conv_it1", pk(0, 0, 13, 25), 0, 0, 0, 1);
        iterate(); expect_out("conv_it2", pk(0, 0, 7, 22), 0, 0, 0, 2);
        iterate(); expect_out("conv_it3", pk(0, 0, 2, 21), 0, 0, 0, 3);
        iterate(); expect_out("conv_it4", pk(0, 0, 0, 21), 1, 3, 1, 4);

        // Non-converging tie
        setup(8'd128, pk(50, 50, 0, 0));
        iterate(); expect_out("tie_it1", pk(25, 25, 0, 0), 0, 0, 0, 1);
        iterate(); expect_out("tie_it2", pk(13, 13, 0, 0), 0, 0, 0, 2);
        iterate(); expect_out("tie_it3", pk(7, 7, 0, 0), 0, 0, 0, 3);
        iterate(); expect_out("tie_it4", pk(4, 4, 0, 0), 0, 0, 0, 4);
        iterate(); expect_out("tie_it5", pk(2, 2, 0, 0), 0, 0, 0, 5);
        iterate(); expect_out("tie_it6", pk(1, 1, 0, 0), 0, 0, 0, 6);
        iterate(); expect_out("tie_it7", pk(1, 1, 0, 0), 0, 0, 0, 7);
        for (int k = 7; k < 300; k++) iterate();
        expect_out("tie_saturate", pk(1, 1, 0, 0), 0, 0, 0, 255);

        // Wide inhibition: P reaches 762, must not wrap in the subtraction
        setup(8'd255, pk(255, 255, 255, 255));
        iterate(); expect_out("wide_p_relu", 32'd0, 1, 0, 0, 1);
        setup(8'd255, pk(255, 0, 0, 1));
        iterate(); expect_out("wide_single", pk(255, 0, 0, 0), 1, 0, 1, 1);

        // Single nonzero input
        setup(8'd64, pk(0, 0, 9, 0));
        expect_out("single_load", pk(0, 0, 9, 0), 1, 2, 1, 0);
        iterate();
        iterate(); expect_out("single_hold", pk(0, 0, 9, 0), 1, 2, 1, 2);

        // Same-edge capture: A takes the old X, X takes the new value
        cyc(0, 0, 0, 1, 8'd0, pk(1, 2, 3, 4));
        cyc(1, 1, 0, 1, 8'd0, pk(5, 6, 7, 8));
        expect_out("same_edge_a", pk(1, 2, 3, 4), 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 32'd0);
        expect_out("same_edge_x", pk(5, 6, 7, 8), 0, 0, 0, 0);

        // Reset mid-iteration 2, between MULT and WB_ACT
        setup(8'd64, pk(10, 20, 30, 40));
        iterate(); expect_out("rst_pre_it1", pk(0, 0, 13, 25), 0, 0, 0, 1);
        idle();
        #2 rst = 1;
        #1 expect_out("rst_async", 32'd0, 1, 0, 0, 0);
        @(negedge clk); #1;
        rst = 0;
        idle();
        idle();
        idle();
        expect_out("rst_hold", 32'd0, 1, 0, 0, 0);

        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            #1;
            if (q.size() > 0) begin
                errors++;
                $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_datapath.md
MAXNET_DATAPATH -- requirements
Module: maxnet_datapath

Interface
REQ-001 The block SHALL provide the following ports:
- clk       input   1   rising-edge clock, sole clock domain
- rst       input   1   reset, asynchronous, active-high
- init_w    input   1   capture w_in into the weight register EPS
- init_x    input   1   capture x_in into the input register X
- load_a    input   1   write the activation registers A0..A3
- load_sel  input   1   A write source during load_a: 1 = X, 0 = computed N
- w_in      input   8   inhibition weight eps, unsigned Q0.8
- x_in      input   32  four unsigned 8-bit inputs; lane i = x_in[8i+7:8i]
- a_out     output  32  A0..A3 packed, same lane order as x_in
- isfinished output 1   at most one A lane is nonzero
- win_idx   output  2   index of the nonzero lane
- win_valid output  1   exactly one lane is nonzero
- iter_cnt  output  8   completed computed iterations, saturating

Function
REQ-002 EPS (8b) SHALL load w_in on any clock edge with init_w=1, and SHALL otherwise hold.
REQ-003 X (4x8b) SHALL load x_in on any clock edge with init_x=1, and SHALL otherwise hold.
REQ-004 Stage 1 register P_i (10b) SHALL update every clock from the current A: P_i = ((sum over j!=i of A_j) * EPS) >> 8.
- The sum is 10b and the product is 18b.
- Truncation SHALL be applied once, to the total, not per term.
REQ-005 Stage 2 register N_i (8b) SHALL update every clock: N_i = A_i - P_i if A_i >= P_i, else 0 (ReLU).
- The subtraction SHALL be evaluated at least 10b wide.
REQ-006 A_i SHALL be written only on edges with load_a=1.
- Source is X_i if load_sel=1, else N_i.
- A_i SHALL hold otherwise.
REQ-007 Computed-data latency SHALL be 2 cycles.
- A written from N is valid only if A was stable for the 2 preceding edges.
- This matches the one-cycle MULT, ADD and WB_ACT controller states.
- The block SHALL NOT check this condition.
REQ-008 Simultaneous init_x and load_a with load_sel=1 SHALL load A from the pre-edge X (register semantics).
- The same rule SHALL apply to init_w with respect to P.
REQ-009 iter_cnt SHALL behave as follows:
- Cleared to 0 on load_a & load_sel.
- Incremented on load_a & ~load_sel.
- Saturates at 255; no wrap.
REQ-010 isfinished SHALL be combinational from A: 1 when the count of nonzero lanes is <= 1, including all-zero.
REQ-011 win_valid SHALL be 1 exactly when one lane is nonzero.
- win_idx SHALL equal that lane when win_valid=1, else 0.
REQ-012 a_out SHALL reflect A directly, with no added latency.
REQ-013 Tied equal maxima that do not converge SHALL leave isfinished=0 indefinitely.
- iter_cnt SHALL saturate in that case.
- Termination is the controller's responsibility.

Reset
REQ-014 rst=1 SHALL asynchronously clear EPS, X, P, N, A and iter_cnt to 0.
REQ-015 During and immediately after reset, outputs SHALL be: a_out=0, isfinished=1, win_valid=0, win_idx=0, iter_cnt=0.
REQ-016 Reset asserted mid-iteration SHALL abort the iteration with no partial write to A.
- After reset release, A SHALL change only on a subsequent load_a.

Verification
REQ-017 Basic convergence.
- Stimulus: w_in=64, x_in lanes {10,20,30,40}; init_w, init_x; load_a+load_sel; then 4 iterations of (2 idle cycles, load_a).
- Required A after each iteration: {0,0,13,25}, {0,0,7,22}, {0,0,2,21}, {0,0,0,21}.
- Final: isfinished=1 only after iteration 4, win_idx=3, win_valid=1, iter_cnt=4.
REQ-018 Non-converging tie.
- Stimulus: w_in=128, lanes {50,50,0,0}.
- Required A sequence: 25,13,7,4,2,1,1 (both lanes 0 and 1 equal).
- isfinished stays 0; iter_cnt reaches 255 and holds after 300 iterations.
REQ-019 Single nonzero input.
- Stimulus: load lanes {0,0,9,0} with load_sel=1.
- Required: isfinished=1, win_idx=2, win_valid=1 immediately; further iterations keep A2=9.
REQ-020 Same-edge capture.
- Stimulus: X holds {1,2,3,4}; drive init_x (x_in={5,6,7,8}) with load_a=1, load_sel=1 on the same edge.
- Required: A={1,2,3,4}, X={5,6,7,8}, iter_cnt=0.
REQ-021 Reset mid-run.
- Stimulus: assert rst between MULT and WB_ACT of iteration 2 of REQ-017.
- Required: all outputs at REQ-015 values within the same cycle; A unchanged by the following load_a=0 cycles.
